// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the CPU control
// path and a DMA/loader port. Each access is arbitrated in IDLE, the winner's
// command is registered and driven for one ACCESS cycle, and read data is
// captured MEM_LAT cycles later and returned with a one-cycle rvalid pulse.
// Optional build macro: MEM_ARB_STATS_EN adds the contention_cnt output.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
`ifdef MEM_ARB_STATS_EN
  output logic [15:0]       contention_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  // Wait counter must hold MEM_LAT-1; keep at least one bit when MEM_LAT==1.
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  // Starvation counter must hold STARVE_MAX.
  localparam int ST_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t              state_reg,      state_next;
  logic                winner_reg,     winner_next;   // 1 = DMA owns the access
  logic                we_reg,         we_next;
  logic [ADDR_W-1:0]   addr_reg,       addr_next;
  logic [DATA_W-1:0]   wdata_reg,      wdata_next;
  logic [CNT_W-1:0]    wait_cnt_reg,   wait_cnt_next;
  logic [ST_W-1:0]     starve_cnt_reg, starve_cnt_next;
  logic                arb_dma;        // DMA wins the current arbitration
  logic                capture;        // mem_rdata is sampled at this edge
  logic                both_req;

  assign both_req = cpu_req & dma_req;

  // State register and latched command; reset aborts any access in flight.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      winner_reg     <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wait_cnt_reg   <= '0;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      winner_reg     <= winner_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      wait_cnt_reg   <= wait_cnt_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Arbitration, command latching and access sequencing.
  always_comb begin
    state_next      = state_reg;
    winner_next     = winner_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    wait_cnt_next   = wait_cnt_reg;
    starve_cnt_next = starve_cnt_reg;
    arb_dma         = 1'b0;
    capture         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cpu_req || dma_req) begin
          // CPU has priority unless DMA has already lost STARVE_MAX times in a row.
          arb_dma     = dma_req && (!cpu_req || (starve_cnt_reg == ST_W'(STARVE_MAX)));
          winner_next = arb_dma;
          we_next     = arb_dma ? dma_we    : cpu_we;
          addr_next   = arb_dma ? dma_addr  : cpu_addr;
          wdata_next  = arb_dma ? dma_wdata : cpu_wdata;
          state_next  = ST_ACCESS;
          if (both_req && !arb_dma) begin
            starve_cnt_next = starve_cnt_reg + ST_W'(1);
          end else begin
            starve_cnt_next = '0;
          end
        end
      end
      ST_ACCESS: begin
        if (we_reg) begin
          state_next = ST_IDLE;
        end else begin
          state_next    = ST_WAIT;
          wait_cnt_next = CNT_W'(MEM_LAT - 1);
        end
      end
      ST_WAIT: begin
        if (wait_cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = ST_IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Memory command is driven straight from the latched registers.
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_we    = (state_reg == ST_ACCESS) && we_reg;
  assign cpu_gnt   = (state_reg == ST_ACCESS) && !winner_reg;
  assign dma_gnt   = (state_reg == ST_ACCESS) &&  winner_reg;

  // Per-port read return: index 0 is the CPU, index 1 is the DMA port.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_port
    logic              sel;
    logic              rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;

    assign sel = (gi == 1) ? winner_reg : ~winner_reg;

    // Capture read data for the owning port only; the other port keeps its value.
    always_ff @(posedge CLK) begin
      if (reset) begin
        rvalid_reg <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= capture && sel;
        if (capture && sel) begin
          rdata_reg <= mem_rdata;
        end
      end
    end
  end

  assign cpu_rvalid = g_port[0].rvalid_reg;
  assign cpu_rdata  = g_port[0].rdata_reg;
  assign dma_rvalid = g_port[1].rvalid_reg;
  assign dma_rdata  = g_port[1].rdata_reg;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] contention_reg;

  // Saturating count of IDLE arbitrations where both ports were requesting.
  always_ff @(posedge CLK) begin
    if (reset) begin
      contention_reg <= '0;
    end else if ((state_reg == ST_IDLE) && both_req && (contention_reg != 16'hFFFF)) begin
      contention_reg <= contention_reg + 16'd1;
    end
  end

  assign contention_cnt = contention_reg;
`endif

endmodule
